crd_rx_buffer: RTL and testbench
================================

CRD_RX_BUFFER -- requirements
Module: crd_rx_buffer

Interface
REQ-001 Param DEPTH, default 4, buffer entries and total credits; legal range 2..15.
REQ-002 Param DATA_W, default 64, flit payload width.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_flitv  input  1  flit valid from upstream sender; each assertion consumes one sender credit.
REQ-006 rx_flit  input  DATA_W  flit payload, sampled when rx_flitv=1.
REQ-007 crd_ret  output  1  registered credit-return pulse; each high cycle returns exactly one credit.
REQ-008 out_valid  output  1  buffer head valid to downstream consumer.
REQ-009 out_data  output  DATA_W  buffer head payload.
REQ-010 out_ready  input  1  downstream accept; pop = out_valid & out_ready.
REQ-011 buf_cnt  output  4  binary occupancy, 0..DEPTH.
REQ-012 init_done  output  1  high once all DEPTH initial credits have been returned.
REQ-013 ovf_err  output  1  sticky error: flit received while buffer full.

Function
REQ-014 Storage SHALL be a DEPTH-entry circular FIFO with read/write pointers wrapping DEPTH-1 -> 0.
REQ-015 Push (rx_flitv=1, not full) in cycle N SHALL make the flit visible at out_data with out_valid=1 no earlier than cycle N+1; no same-cycle bypass.
REQ-016 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-017 Full is evaluated on pre-cycle occupancy; push while full SHALL drop the flit and set ovf_err, even with a same-cycle pop.
REQ-018 Simultaneous push and pop when not full and not empty SHALL leave buf_cnt unchanged.
REQ-019 Pending-credit register P (4 bits): avail = P + pop; crd_ret_d = (avail != 0); P_next = avail - crd_ret_d; crd_ret flop <= crd_ret_d.
REQ-020 Pop in cycle N with P=0 SHALL produce crd_ret=1 in cycle N+1; at most one crd_ret per cycle, backlog drained one per cycle.
REQ-021 FSM states: INIT, RUN; INIT entered on reset; INIT->RUN when DEPTH initial credits have been issued; RUN has no exit except reset.
REQ-022 In INIT, crd_ret SHALL be high for exactly DEPTH consecutive cycles starting the first cycle after reset deasserts, plus any pop-generated credits afterward.
REQ-023 init_done SHALL be 1 iff state is RUN.
REQ-024 Flits accepted during INIT SHALL be stored and popped normally; pop credits queue behind initial credits.
REQ-025 Invariant when no flit in flight: buf_cnt + P + crd_ret_in_flight = DEPTH; P SHALL never exceed DEPTH.

Reset
REQ-026 reset SHALL clear pointers, buf_cnt=0, out_valid=0, crd_ret=0, ovf_err=0, state=INIT, P=DEPTH.
REQ-027 Reset asserted mid-operation SHALL discard buffered flits and pending credits and restart the initial-credit sequence; FIFO data RAM needs no reset.

Structure
REQ-028 Shared package SHALL hold the state enum {INIT, RUN} and the 4-bit credit-count width constant, common with the sender-side credit counter.
REQ-029 One sub-module, crd_rx_fifo (storage, pointers, occupancy), SHALL be instantiated; credit logic and FSM reside in the top.

Verification
REQ-030 Reset release, DEPTH=4, no traffic -> crd_ret high cycles 1-4, low after; init_done=1 from cycle 5; buf_cnt=0.
REQ-031 Push 0xA5 at cycle 10, out_ready=1 -> out_valid/out_data=0xA5 cycle 11, pop cycle 11, crd_ret=1 cycle 12.
REQ-032 Fill 4 flits with out_ready=0, then out_ready=1 for 4 cycles -> in-order data, crd_ret high 4 consecutive cycles, buf_cnt 4->0.
REQ-033 Buffer full, push 5th flit with same-cycle pop -> 5th flit dropped, ovf_err=1 stays set, buf_cnt=3.
REQ-034 Push during INIT cycle 2, pop cycle 3 -> total crd_ret pulses = 5, last pulse cycle 5, init_done at cycle 5.
REQ-035 Assert reset with buf_cnt=3, P=1 -> next cycle buf_cnt=0, out_valid=0; after release crd_ret high 4 cycles exactly.

Source files
------------

// File: rtl/crd_rx_buffer_pkg.sv
// ----------------------------------------------------------------------------
// crd_rx_buffer_pkg
// Shared definitions for the credit-based receive buffer. The sender-side
// credit counter uses the same types.
//   CRD_CNT_W   : width of every credit / occupancy counter (4 bits)
//   crd_cnt_t   : credit / occupancy count type
//   crd_state_e : credit FSM states (ST_INIT, ST_RUN)
// ----------------------------------------------------------------------------
package crd_rx_buffer_pkg;

    localparam int CRD_CNT_W = 4;

    typedef logic [CRD_CNT_W-1:0] crd_cnt_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } crd_state_e;

endpackage

// File: rtl/crd_rx_buffer_if.sv
// ----------------------------------------------------------------------------
// crd_rx_buffer_if
// Bundles the link-side and consumer-side signals of the receive buffer.
//   rx_flitv / rx_flit : flit from upstream sender (one credit per flit)
//   crd_ret            : one-cycle credit-return pulse to the sender
//   out_valid/out_data : buffer head to the downstream consumer
//   out_ready          : downstream accept
//   buf_cnt            : buffer occupancy
//   init_done          : all initial credits issued
//   ovf_err            : sticky overflow flag
// Modports: master = environment (sender + consumer), slave = the buffer.
// ----------------------------------------------------------------------------
interface crd_rx_buffer_if
    import crd_rx_buffer_pkg::*;
#(
    parameter int DATA_W = 64
);

    logic              rx_flitv;
    logic [DATA_W-1:0] rx_flit;
    logic              crd_ret;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    crd_cnt_t          buf_cnt;
    logic              init_done;
    logic              ovf_err;

    modport master (
        output rx_flitv, rx_flit, out_ready,
        input  crd_ret, out_valid, out_data, buf_cnt, init_done, ovf_err
    );

    modport slave (
        input  rx_flitv, rx_flit, out_ready,
        output crd_ret, out_valid, out_data, buf_cnt, init_done, ovf_err
    );

endinterface

// File: rtl/crd_rx_fifo.sv
// ----------------------------------------------------------------------------
// crd_rx_fifo
// DEPTH-entry circular FIFO holding received flits. Head is read straight
// from the storage array, so a pushed flit is visible the cycle after push.
//   clock, reset : clock and synchronous active-high reset
//   i_push       : push request (ignored when full)
//   i_pushData   : flit written on an accepted push
//   i_pop        : pop request (ignored when empty)
//   o_full       : occupancy == DEPTH
//   o_valid      : occupancy != 0
//   o_data       : head entry
//   o_count      : occupancy 0..DEPTH
// ----------------------------------------------------------------------------
module crd_rx_fifo
    import crd_rx_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_pushData,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output crd_cnt_t          o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    crd_cnt_t          r_count;
    logic              w_push;
    logic              w_pop;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Full is judged on the occupancy at the start of the cycle, so a push
    // into a full buffer is dropped even if a pop frees a slot this cycle.
    assign o_full  = (r_count == CRD_CNT_W'(DEPTH));
    assign o_valid = (r_count != '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & o_valid;
    assign o_data  = r_mem[r_rdPtr];
    assign o_count = r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= nextPtr(r_wrPtr);
            if (w_pop)  r_rdPtr <= nextPtr(r_rdPtr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + crd_cnt_t'(1);
                2'b01:   r_count <= r_count - crd_cnt_t'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage has no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wrPtr] <= i_pushData;
    end

endmodule

// File: rtl/crd_rx_buffer.sv
// ----------------------------------------------------------------------------
// crd_rx_buffer
// Credit-based receive buffer. After reset it hands DEPTH initial credits to
// the sender, one per cycle, then returns one credit per popped flit.
//   clock, reset : clock and synchronous active-high reset
//   bus          : crd_rx_buffer_if slave (flit in, credit return, head out,
//                  occupancy, init_done, ovf_err)
// ----------------------------------------------------------------------------
module crd_rx_buffer
    import crd_rx_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
) (
    input  logic           clock,
    input  logic           reset,
    crd_rx_buffer_if.slave bus
);

    crd_state_e         r_state;
    crd_state_e         w_stateNext;
    crd_cnt_t           r_pend;
    crd_cnt_t           r_initCnt;
    logic               r_crdRet;
    logic               r_ovfErr;
    logic               w_full;
    logic               w_outValid;
    logic [DATA_W-1:0]  w_outData;
    crd_cnt_t           w_count;
    logic               w_pop;
    logic               w_crdRetD;
    logic [CRD_CNT_W:0] w_avail;

    crd_rx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .i_push     (bus.rx_flitv),
        .i_pushData (bus.rx_flit),
        .i_pop      (w_pop),
        .o_full     (w_full),
        .o_valid    (w_outValid),
        .o_data     (w_outData),
        .o_count    (w_count)
    );

    assign w_pop = w_outValid & bus.out_ready;

    // Pending credits start at DEPTH, so the initial credits and pop credits
    // share one queue; pop credits naturally drain after the initial ones.
    assign w_avail   = {1'b0, r_pend} + {{CRD_CNT_W{1'b0}}, w_pop};
    assign w_crdRetD = (w_avail != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend    <= CRD_CNT_W'(DEPTH);
            r_crdRet  <= 1'b0;
            r_ovfErr  <= 1'b0;
            r_initCnt <= '0;
        end else begin
            r_pend   <= CRD_CNT_W'(w_avail - {{CRD_CNT_W{1'b0}}, w_crdRetD});
            r_crdRet <= w_crdRetD;
            r_ovfErr <= r_ovfErr | (bus.rx_flitv & w_full);
            // The first DEPTH pulses after reset are always the initial ones,
            // since the pending count stays nonzero until they are all out.
            if (r_state == ST_INIT && r_crdRet) begin
                r_initCnt <= r_initCnt + crd_cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_INIT;
        else       r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_INIT: begin
                if (r_crdRet && r_initCnt == crd_cnt_t'(DEPTH - 1)) begin
                    w_stateNext = ST_RUN;
                end
            end
            ST_RUN: w_stateNext = ST_RUN;
        endcase
    end

    assign bus.crd_ret   = r_crdRet;
    assign bus.out_valid = w_outValid;
    assign bus.out_data  = w_outData;
    assign bus.buf_cnt   = w_count;
    assign bus.init_done = (r_state == ST_RUN);
    assign bus.ovf_err   = r_ovfErr;

endmodule

// File: tb/tb_crd_rx_buffer.sv
// ----------------------------------------------------------------------------
// tb_crd_rx_buffer
// Directed bench for crd_rx_buffer (DEPTH=4, DATA_W=64). A per-cycle vector
// table covers initial credits, single transfer, fill/drain and overflow;
// two hand-written sequences cover a push/pop during INIT and a mid-run reset.
// ----------------------------------------------------------------------------
module tb_crd_rx_buffer;
    import crd_rx_buffer_pkg::*;

    localparam logic [63:0] A5 = 64'h0000_0000_0000_00A5;
    localparam logic [63:0] D0 = 64'h1111_0000_0000_0010;
    localparam logic [63:0] D1 = 64'h2222_0000_0000_0011;
    localparam logic [63:0] D2 = 64'h3333_0000_0000_0012;
    localparam logic [63:0] D3 = 64'h4444_0000_0000_0013;
    localparam logic [63:0] E0 = 64'hE000_0000_0000_00E0;
    localparam logic [63:0] E1 = 64'hE111_0000_0000_00E1;
    localparam logic [63:0] E2 = 64'hE222_0000_0000_00E2;
    localparam logic [63:0] E3 = 64'hE333_0000_0000_00E3;
    localparam logic [63:0] E4 = 64'hE444_0000_0000_00E4;
    localparam logic [63:0] Z  = 64'h0;

    typedef struct {
        logic        flitv;
        logic [63:0] flit;
        logic        ready;
        logic        crd;
        logic        valid;
        logic [63:0] data;
        logic [3:0]  cnt;
        logic        init;
        logic        ovf;
    } vec_t;

    logic clock;
    logic reset;
    int   totalCount;
    int   badCount;
    vec_t vecs[$];

    crd_rx_buffer_if #(.DATA_W(64)) bus ();

    crd_rx_buffer #(
        .DEPTH  (4),
        .DATA_W (64)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void addVec(input logic fv, input logic [63:0] fl, input logic rdy,
                                   input logic crd, input logic vld, input logic [63:0] dat,
                                   input logic [3:0] cnt, input logic ini, input logic ovf);
        vec_t v;
        v.flitv = fv;  v.flit = fl;   v.ready = rdy;
        v.crd   = crd; v.valid = vld; v.data  = dat;
        v.cnt   = cnt; v.init  = ini; v.ovf   = ovf;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input logic fv, input logic [63:0] fl, input logic rdy);
        bus.rx_flitv  = fv;
        bus.rx_flit   = fl;
        bus.out_ready = rdy;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCount++;
        if (act !== exp) begin
            badCount++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // Holds reset over two edges; on return the bench is in cycle 0, the
    // first cycle with reset low.
    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, Z, 1'b0);
        nextCycle();
        nextCycle();
        reset = 1'b0;
    endtask

    initial begin
        int pulses;
        int firstPulse;
        int lastPulse;
        int firstInit;

        totalCount = 0;
        badCount   = 0;
        reset      = 1'b1;
        applyStimulus(1'b0, Z, 1'b0);

        // cycle 0..9: reset state, four initial credits, then RUN
        addVec(1'b0, Z, 1'b0,  1'b0, 1'b0, Z, 4'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) addVec(1'b0, Z, 1'b0,  1'b1, 1'b0, Z, 4'd0, 1'b0, 1'b0);
        for (int k = 5; k <= 9; k++) addVec(1'b0, Z, 1'b0,  1'b0, 1'b0, Z, 4'd0, 1'b1, 1'b0);
        // cycle 10..12: single flit, popped at once, credit one cycle later
        addVec(1'b1, A5, 1'b1, 1'b0, 1'b0, Z,  4'd0, 1'b1, 1'b0);
        addVec(1'b0, Z,  1'b1, 1'b0, 1'b1, A5, 4'd1, 1'b1, 1'b0);
        addVec(1'b0, Z,  1'b0, 1'b1, 1'b0, Z,  4'd0, 1'b1, 1'b0);
        // cycle 13..21: fill four with consumer stalled, then drain in order
        addVec(1'b1, D0, 1'b0, 1'b0, 1'b0, Z,  4'd0, 1'b1, 1'b0);
        addVec(1'b1, D1, 1'b0, 1'b0, 1'b1, D0, 4'd1, 1'b1, 1'b0);
        addVec(1'b1, D2, 1'b0, 1'b0, 1'b1, D0, 4'd2, 1'b1, 1'b0);
        addVec(1'b1, D3, 1'b0, 1'b0, 1'b1, D0, 4'd3, 1'b1, 1'b0);
        addVec(1'b0, Z,  1'b1, 1'b0, 1'b1, D0, 4'd4, 1'b1, 1'b0);
        addVec(1'b0, Z,  1'b1, 1'b1, 1'b1, D1, 4'd3, 1'b1, 1'b0);
        addVec(1'b0, Z,  1'b1, 1'b1, 1'b1, D2, 4'd2, 1'b1, 1'b0);
        addVec(1'b0, Z,  1'b1, 1'b1, 1'b1, D3, 4'd1, 1'b1, 1'b0);
        addVec(1'b0, Z,  1'b0, 1'b1, 1'b0, Z,  4'd0, 1'b1, 1'b0);
        // cycle 22..33: fill, push a fifth flit with a same-cycle pop (dropped)
        addVec(1'b1, E0, 1'b0, 1'b0, 1'b0, Z,  4'd0, 1'b1, 1'b0);
        addVec(1'b1, E1, 1'b0, 1'b0, 1'b1, E0, 4'd1, 1'b1, 1'b0);
        addVec(1'b1, E2, 1'b0, 1'b0, 1'b1, E0, 4'd2, 1'b1, 1'b0);
        addVec(1'b1, E3, 1'b0, 1'b0, 1'b1, E0, 4'd3, 1'b1, 1'b0);
        addVec(1'b1, E4, 1'b1, 1'b0, 1'b1, E0, 4'd4, 1'b1, 1'b0);
        addVec(1'b0, Z,  1'b0, 1'b1, 1'b1, E1, 4'd3, 1'b1, 1'b1);
        addVec(1'b0, Z,  1'b0, 1'b0, 1'b1, E1, 4'd3, 1'b1, 1'b1);
        addVec(1'b0, Z,  1'b1, 1'b0, 1'b1, E1, 4'd3, 1'b1, 1'b1);
        addVec(1'b0, Z,  1'b1, 1'b1, 1'b1, E2, 4'd2, 1'b1, 1'b1);
        addVec(1'b0, Z,  1'b1, 1'b1, 1'b1, E3, 4'd1, 1'b1, 1'b1);
        addVec(1'b0, Z,  1'b0, 1'b1, 1'b0, Z,  4'd0, 1'b1, 1'b1);
        addVec(1'b0, Z,  1'b0, 1'b0, 1'b0, Z,  4'd0, 1'b1, 1'b1);

        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            checkOutput($sformatf("c%0d crd_ret", i),   64'(bus.crd_ret),   64'(vecs[i].crd));
            checkOutput($sformatf("c%0d out_valid", i), 64'(bus.out_valid), 64'(vecs[i].valid));
            checkOutput($sformatf("c%0d buf_cnt", i),   64'(bus.buf_cnt),   64'(vecs[i].cnt));
            checkOutput($sformatf("c%0d init_done", i), 64'(bus.init_done), 64'(vecs[i].init));
            checkOutput($sformatf("c%0d ovf_err", i),   64'(bus.ovf_err),   64'(vecs[i].ovf));
            if (vecs[i].valid) begin
                checkOutput($sformatf("c%0d out_data", i), bus.out_data, vecs[i].data);
            end
            applyStimulus(vecs[i].flitv, vecs[i].flit, vecs[i].ready);
            nextCycle();
        end

        // Push in INIT cycle 2, pop in cycle 3: five pulses, last at cycle 5.
        doReset();
        pulses    = 0;
        lastPulse = -1;
        firstInit = -1;
        for (int c = 0; c < 12; c++) begin
            if (bus.crd_ret) begin
                pulses++;
                lastPulse = c;
            end
            if (bus.init_done && firstInit < 0) firstInit = c;
            if (c == 0) begin
                checkOutput("initSeq ovf_err cleared", 64'(bus.ovf_err), 64'd0);
                checkOutput("initSeq buf_cnt cleared", 64'(bus.buf_cnt), 64'd0);
            end
            if (c == 3) begin
                checkOutput("initSeq out_valid c3", 64'(bus.out_valid), 64'd1);
                checkOutput("initSeq out_data c3", bus.out_data, 64'hBEEF);
            end
            applyStimulus(c == 2, 64'hBEEF, c == 3);
            nextCycle();
        end
        checkOutput("initSeq pulse count", 64'(pulses), 64'd5);
        checkOutput("initSeq last pulse", 64'(lastPulse), 64'd5);
        checkOutput("initSeq init_done cycle", 64'(firstInit), 64'd5);

        // Three flits parked during INIT (buf_cnt=3, P=1), then reset.
        doReset();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 64'(c + 100), 1'b0);
            nextCycle();
        end
        checkOutput("midReset buf_cnt before", 64'(bus.buf_cnt), 64'd3);
        checkOutput("midReset crd_ret before", 64'(bus.crd_ret), 64'd1);
        applyStimulus(1'b0, Z, 1'b0);
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        checkOutput("midReset buf_cnt after", 64'(bus.buf_cnt), 64'd0);
        checkOutput("midReset out_valid after", 64'(bus.out_valid), 64'd0);
        checkOutput("midReset crd_ret after", 64'(bus.crd_ret), 64'd0);
        pulses     = 0;
        firstPulse = -1;
        lastPulse  = -1;
        for (int c = 0; c < 10; c++) begin
            if (bus.crd_ret) begin
                pulses++;
                if (firstPulse < 0) firstPulse = c;
                lastPulse = c;
            end
            nextCycle();
        end
        checkOutput("midReset pulse count", 64'(pulses), 64'd4);
        checkOutput("midReset first pulse", 64'(firstPulse), 64'd1);
        checkOutput("midReset last pulse", 64'(lastPulse), 64'd4);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
